data_mem_ctrl: RTL and testbench

//  Byte-addressable, little-endian data memory with a valid/ready request port and a buffered response port.

---
 rtl/mem_pkg.sv | 8 +
 rtl/load_align.sv | 18 +
 rtl/data_mem_ctrl.sv | 60 ++++++
 tb/tb_data_mem_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encodings, response states and size helper for the data memory
package mem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic {EMPTY, FULL} state_e;
  function automatic int size_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: keeps the low 2^size bytes of a raw little-endian window and sign/zero extends to W
module load_align import mem_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0] raw,
  input  logic [1:0]   size,
  input  logic         uns,
  output logic [W-1:0] data
);
  localparam int NB = W / 8;
  logic sign;
  always_comb begin
    sign = 1'b0;
    for (int i = 0; i < NB; i++) if (i == size_bytes(size) - 1) sign = raw[8*i+7] & ~uns;
    data = raw;
    for (int i = 0; i < NB; i++) if (i >= size_bytes(size)) data[8*i+:8] = {8{sign}};
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable little-endian data memory with valid/ready requests and a held response
module data_mem_ctrl import mem_pkg::*; #(
  parameter int W = 32,
  parameter int L = 64,
  localparam int AW = $clog2(L * (W / 8))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [W-1:0]  req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [W-1:0]  resp_rdata,
  output logic          resp_err
);
  localparam int NB = W / 8;
  localparam int BYTES = L * NB;
  logic [7:0] mem [BYTES];
  state_e state_q, state_d;
  logic [W-1:0] rdata_q, rdata_d, raw, ld_data;
  logic err_q, err_d, acc, bad;
  int n;
  always_comb begin
    n = size_bytes(req_size);
    bad = n > NB || (int'(req_addr) & (n - 1)) != 0 || int'(req_addr) + n > BYTES;
    for (int i = 0; i < NB; i++)
      raw[8*i+:8] = int'(req_addr) + i < BYTES ? mem[AW'(int'(req_addr) + i)] : 8'h00;
  end
  load_align #(.W(W)) u_align (.raw(raw), .size(req_size), .uns(req_unsigned), .data(ld_data));
  assign req_ready = state_q == EMPTY || resp_ready;
  always_comb begin
    acc = req_valid && req_ready;
    state_d = acc ? FULL : resp_ready ? EMPTY : state_q;
    err_d = acc ? bad : err_q;
    rdata_d = acc ? (bad || req_we ? '0 : ld_data) : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  // Reset wins over a same-cycle store; rejected accesses never touch storage.
  always_ff @(posedge clk)
    if (!reset && acc && req_we && !bad)
      for (int i = 0; i < NB; i++) if (i < n) mem[AW'(int'(req_addr) + i)] <= req_wdata[8*i+:8];
  assign resp_valid = state_q == FULL;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed literal checks plus randomized traffic against a byte-array reference model
module tb_data_mem_ctrl;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_we = 0, req_unsigned = 0, resp_valid, resp_ready = 1, resp_err;
  logic [1:0] req_size = 0;
  logic [7:0] req_addr = 0;
  logic [31:0] req_wdata = 0, resp_rdata;
  logic q_valid = 0, q_ready, q_we = 0, q_uns = 0, q_rvalid, q_err;
  logic [1:0] q_size = 0;
  logic [6:0] q_addr = 0;
  logic [63:0] q_wdata = 0, q_rdata;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  logic [7:0] mm [256];
  bit mv = 0, me = 0;
  logic [31:0] md = 0;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  data_mem_ctrl #(.W(64), .L(16)) d64 (
    .clk(clk), .reset(reset), .req_valid(q_valid), .req_ready(q_ready), .req_we(q_we),
    .req_size(q_size), .req_unsigned(q_uns), .req_addr(q_addr), .req_wdata(q_wdata),
    .resp_valid(q_rvalid), .resp_ready(1'b1), .resp_rdata(q_rdata), .resp_err(q_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: one held response, byte array storage, arithmetic extension.
  initial begin
    int n;
    bit e, acc;
    longint v;
    for (int k = 0; k < 256; k++) mm[k] = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mv = 0; me = 0; md = 0;
      end else begin
        acc = req_valid && (!mv || resp_ready);
        if (acc) begin
          n = 1 << req_size;
          e = n > 4 || (int'(req_addr) % n) != 0 || int'(req_addr) + n > 256;
          v = 0;
          if (!e)
            for (int k = 0; k < n; k++)
              if (req_we) mm[int'(req_addr) + k] = req_wdata[8*k+:8];
              else v = v | (longint'(mm[int'(req_addr) + k]) << (8 * k));
          if (!e && !req_we && !req_unsigned && v[8*n-1]) v = v - (longint'(1) << (8 * n));
          md = (e || req_we) ? 32'h0 : v[31:0];
          me = e;
          mv = 1;
        end else if (resp_ready) mv = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_ready", req_ready, !mv || resp_ready);
      chk("m_valid", resp_valid, mv);
      if (mv) begin
        chk("m_rdata", resp_rdata, md);
        chk("m_err", resp_err, me);
      end
    end
  end

  task automatic xfer(input logic we, input logic [1:0] sz, input logic uns, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e, input string nm);
    int t = 0;
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t == 20) chk({nm, "_accept"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    chk({nm, "_valid"}, resp_valid, 1);
    chk({nm, "_rdata"}, resp_rdata, exp_d);
    chk({nm, "_err"}, resp_err, exp_e);
  endtask

  task automatic xf64(input logic we, input logic [1:0] sz, input logic uns, input logic [6:0] a,
                      input logic [63:0] wd, input logic [63:0] exp_d, input logic exp_e, input string nm);
    int t = 0;
    q_valid = 1; q_we = we; q_size = sz; q_uns = uns; q_addr = a; q_wdata = wd;
    while (!q_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t == 20) chk({nm, "_accept"}, q_ready, 1);
    @(posedge clk); #1;
    q_valid = 0;
    chk({nm, "_valid"}, q_rvalid, 1);
    chk({nm, "_rdata"}, q_rdata, exp_d);
    chk({nm, "_err"}, q_err, exp_e);
  endtask

  initial begin
    logic [31:0] bexp [4] = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
    @(posedge clk); #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_valid64", q_rvalid, 0);
    reset = 0;
    chk_en = 1;
    xfer(1, 2, 0, 8'h10, 32'hDEADBEEF, 32'h0, 0, "st_w10");
    xfer(0, 2, 0, 8'h10, 32'h0, 32'hDEADBEEF, 0, "ld_w10");
    xfer(0, 0, 0, 8'h13, 32'h0, 32'hFFFFFFDE, 0, "ld_b13s");
    xfer(0, 0, 1, 8'h13, 32'h0, 32'h000000DE, 0, "ld_b13u");
    xfer(0, 1, 0, 8'h12, 32'h0, 32'hFFFFDEAD, 0, "ld_h12s");
    xfer(1, 1, 0, 8'h11, 32'h0000FFFF, 32'h0, 1, "st_h11_mis");
    xfer(0, 2, 0, 8'h10, 32'h0, 32'hDEADBEEF, 0, "ld_w10_after");
    xfer(0, 2, 0, 8'hFC, 32'h0, 32'h0, 0, "ld_wFC");
    xfer(0, 2, 0, 8'hFE, 32'h0, 32'h0, 1, "ld_wFE_mis");
    xfer(0, 3, 0, 8'h10, 32'h0, 32'h0, 1, "ld_d_w32");
    xfer(0, 1, 1, 8'hFE, 32'h0, 32'h0, 0, "ld_hFE");
    // Back-pressure: response held, then release with a pending request.
    @(posedge clk); #1;
    resp_ready = 0;
    req_valid = 1; req_we = 0; req_size = 2; req_unsigned = 0; req_addr = 8'h10;
    @(posedge clk); #1;
    req_size = 0; req_addr = 8'h13;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", resp_valid, 1);
      chk("bp_rdata", resp_rdata, 32'hDEADBEEF);
    end
    resp_ready = 1;
    #1 chk("bp_release_ready", req_ready, 1);
    @(posedge clk); #1;
    chk("bp_pending", resp_rdata, 32'hFFFFFFDE);
    req_unsigned = 1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 8'(8'h10 + i);
      @(posedge clk); #1;
      chk("b2b_rdata", resp_rdata, bexp[i]);
      chk("b2b_valid", resp_valid, 1);
    end
    req_valid = 0;
    @(posedge clk); #1;
    chk("b2b_drain", resp_valid, 0);
    // Reset colliding with a store accept.
    req_valid = 1; req_we = 1; req_size = 2; req_addr = 8'h20; req_wdata = 32'h12345678;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; req_valid = 0;
    chk("rst_acc_valid", resp_valid, 0);
    xfer(0, 2, 0, 8'h20, 32'h0, 32'h0, 0, "ld_w20_after_rst");
    xf64(1, 3, 0, 7'h08, 64'h0123456789ABCDEF, 64'h0, 0, "w64_st_d08");
    xf64(0, 3, 0, 7'h08, 64'h0, 64'h0123456789ABCDEF, 0, "w64_ld_d08");
    xf64(0, 2, 0, 7'h0C, 64'h0, 64'h0000000001234567, 0, "w64_ld_w0C");
    xf64(0, 0, 0, 7'h08, 64'h0, 64'hFFFFFFFFFFFFFFEF, 0, "w64_ld_b08s");
    xf64(0, 3, 0, 7'h04, 64'h0, 64'h0, 1, "w64_ld_d04_mis");
    xf64(1, 3, 0, 7'h04, 64'h1111, 64'h0, 1, "w64_st_d04_mis");
    xf64(0, 3, 0, 7'h00, 64'h0, 64'h0, 0, "w64_ld_d00");
    xf64(0, 2, 1, 7'h7C, 64'h0, 64'h0, 0, "w64_ld_w7C");
    repeat (800) begin
      @(posedge clk); #1;
      reset = $urandom_range(0, 99) == 0;
      resp_ready = $urandom_range(0, 3) != 0;
      req_valid = $urandom_range(0, 2) != 0;
      req_we = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      req_addr = 8'($urandom_range(0, 31) + ($urandom_range(0, 3) == 0 ? 224 : 0));
      if ($urandom_range(0, 3) != 0) req_addr = req_addr & ~8'((1 << req_size) - 1);
      req_wdata = $urandom;
    end
    @(posedge clk); #1;
    reset = 0; req_valid = 0; resp_ready = 1;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
